// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-wide lookahead slice per register stage.
// Define PIPE_ADDER_OVF_EN to add the registered two's-complement overflow output ovf.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int BLK    = (BLOCK < 1) ? 1 : BLOCK;
  localparam int STAGES = WIDTH / BLK;

  generate
    if (BLOCK < 1 || (WIDTH % BLK) != 0 || STAGES < 1) begin : g_bad_params
      $error("pipelined_cla_adder: WIDTH must be a positive multiple of BLOCK (BLOCK >= 1)");
    end
  endgenerate

  logic advance;
  assign advance  = out_ready || !out_valid;
  assign in_ready = advance;

  // Flat lookahead: each carry is an OR of generate terms gated by the propagate run below it.
  function automatic logic [BLK:0] cla_block(input logic [BLK-1:0] x,
                                             input logic [BLK-1:0] y,
                                             input logic           c0);
    logic [BLK-1:0] g;
    logic [BLK-1:0] p;
    logic [BLK:0]   c;
    logic           run;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < BLK; i++) begin
      c[i+1] = g[i];
      run    = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (run & g[j]);
        run    = run & p[j];
      end
      c[i+1] = c[i+1] | (run & c0);
    end
    return {c[BLK], p ^ c[BLK-1:0]};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO  = gi * BLK;
      localparam int REM = WIDTH - LO;

      // Operands still to be summed shrink by one block per stage; finished sum bits grow.
      logic [REM-1:0]      a_in;
      logic [REM-1:0]      b_in;
      logic                c_in;
      logic                v_in;
      logic [BLK:0]        blk_next;
      logic [LO+BLK-1:0]   s_next;
      logic [LO+BLK-1:0]   s_reg;
      logic                c_reg;
      logic                v_reg;

      assign blk_next = cla_block(a_in[BLK-1:0], b_in[BLK-1:0], c_in);

      if (gi == 0) begin : g_head
        assign a_in   = a;
        assign b_in   = b ^ {WIDTH{sub}};
        assign c_in   = cin ^ sub;
        assign v_in   = in_valid;
        assign s_next = blk_next[BLK-1:0];
      end else begin : g_link
        assign a_in   = g_stage[gi-1].g_fwd.a_reg;
        assign b_in   = g_stage[gi-1].g_fwd.b_reg;
        assign c_in   = g_stage[gi-1].c_reg;
        assign v_in   = g_stage[gi-1].v_reg;
        assign s_next = {blk_next[BLK-1:0], g_stage[gi-1].s_reg};
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_reg <= '0;
          c_reg <= 1'b0;
          v_reg <= 1'b0;
        end else if (advance) begin
          s_reg <= s_next;
          c_reg <= blk_next[BLK];
          v_reg <= v_in;
        end
      end

      if (gi < STAGES - 1) begin : g_fwd
        logic [REM-BLK-1:0] a_reg;
        logic [REM-BLK-1:0] b_reg;

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
          end else if (advance) begin
            a_reg <= a_in[REM-1:BLK];
            b_reg <= b_in[REM-1:BLK];
          end
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[STAGES-1].v_reg;
  assign sum       = g_stage[STAGES-1].s_reg;
  assign cout      = g_stage[STAGES-1].c_reg;

`ifdef PIPE_ADDER_OVF_EN
  // The final stage still sees the operand MSBs, so overflow is resolved alongside the top block.
  logic ovf_next;
  logic ovf_reg;

  assign ovf_next = (g_stage[STAGES-1].a_in[BLK-1] == g_stage[STAGES-1].b_in[BLK-1]) &&
                    (g_stage[STAGES-1].blk_next[BLK-1] != g_stage[STAGES-1].a_in[BLK-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (advance) begin
      ovf_reg <= ovf_next;
    end
  end

  assign ovf = ovf_reg;
`endif

endmodule
